kw_frame_ctrl: RTL and testbench

Byte-stream command controller that sequences loading of the 32-bit control words (frequency, phase, amplitude, mode) for the signal-generation datapath. It sits between the UART receiver and the DDS core. It parses framed write commands from the `rx_data`/`rx_valid` byte stream, stages each word in a shadow register, and commits all shadows to the outputs atomically so the datapath never sees a half-updated configuration.

---
 rtl/kw_frame_ctrl.sv | 174 +++++++++++++++++
 tb/tb_kw_frame_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/kw_frame_ctrl.sv
// kw_frame_ctrl: parses HDR/ADDR/D0..D3[/CSUM] write frames and atomically commits fw/pw/aw/mode.
// Build option KW_CHECKSUM_EN adds the CSUM byte; outputs and upd land 2 cycles after the last byte.
module kw_frame_ctrl #(
  parameter int          TIMEOUT = 5_000_000,
  parameter logic [7:0]  HDR     = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [31:0] fw,
  output logic [31:0] pw,
  output logic [31:0] aw,
  output logic [31:0] mode,
  output logic        upd,
  output logic        err,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_D0, S_D1, S_D2, S_D3, S_CSUM, S_APPLY
  } state_t;

  localparam logic [23:0] TO_LAST = 24'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [7:0]        addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [23:0]       cnt_q, cnt_d;
  logic [3:0][31:0]  shadow_q, shadow_d;
  logic [3:0][31:0]  out_q, out_d;
  logic              upd_q, upd_d;
  logic              err_q, err_d;
`ifdef KW_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic addr_write, addr_commit, addr_ok;

  // 0x00-0x03 / 0x80-0x83 write a shadow; bit 7 or the 0x40 code requests a commit.
  assign addr_write  = (addr_q[6:2] == 5'd0);
  assign addr_commit = (addr_write && addr_q[7]) || (addr_q == 8'h40);
  assign addr_ok     = addr_write || (addr_q == 8'h40);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    shadow_d = shadow_q;
    out_d    = out_q;
    upd_d    = 1'b0;
    err_d    = 1'b0;
`ifdef KW_CHECKSUM_EN
    csum_d   = csum_q;
`endif

    if (state_q == S_IDLE || state_q == S_APPLY || rx_valid) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 24'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (rx_valid && rx_data == HDR) begin
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (rx_valid) begin
          addr_d  = rx_data;
          state_d = S_D0;
`ifdef KW_CHECKSUM_EN
          csum_d  = rx_data;
`endif
        end
      end
      S_D0, S_D1, S_D2, S_D3: begin
        if (rx_valid) begin
          // Bytes arrive LSB first, so shift in from the top.
          data_d = {rx_data, data_q[31:8]};
`ifdef KW_CHECKSUM_EN
          csum_d = csum_q ^ rx_data;
`endif
          case (state_q)
            S_D0:    state_d = S_D1;
            S_D1:    state_d = S_D2;
            S_D2:    state_d = S_D3;
            default: begin
`ifdef KW_CHECKSUM_EN
              state_d = S_CSUM;
`else
              if (addr_ok) begin
                state_d = S_APPLY;
              end else begin
                state_d = S_IDLE;
                err_d   = 1'b1;
              end
`endif
            end
          endcase
        end
      end
      S_CSUM: begin
`ifdef KW_CHECKSUM_EN
        if (rx_valid) begin
          if (addr_ok && rx_data == csum_q) begin
            state_d = S_APPLY;
          end else begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end
        end
`else
        state_d = S_IDLE;
`endif
      end
      S_APPLY: begin
        if (addr_write) begin
          shadow_d[addr_q[1:0]] = data_q;
        end
        // Commit from the updated shadows so a write+commit frame lands in one step.
        if (addr_commit) begin
          out_d = shadow_d;
          upd_d = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q != S_IDLE && state_q != S_APPLY && !rx_valid && cnt_q == TO_LAST) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      out_q    <= '0;
      upd_q    <= 1'b0;
      err_q    <= 1'b0;
`ifdef KW_CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      out_q    <= out_d;
      upd_q    <= upd_d;
      err_q    <= err_d;
`ifdef KW_CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

  assign fw   = out_q[0];
  assign pw   = out_q[1];
  assign aw   = out_q[2];
  assign mode = out_q[3];
  assign upd  = upd_q;
  assign err  = err_q;
  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_kw_frame_ctrl.sv
// Directed bench for kw_frame_ctrl; frame format follows KW_CHECKSUM_EN.
module tb_kw_frame_ctrl;

  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [31:0] fw, pw, aw, mode;
  logic        upd, err, busy;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_aw;

  kw_frame_ctrl #(.TIMEOUT(TO), .HDR(8'hA5)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .fw       (fw),
    .pw       (pw),
    .aw       (aw),
    .mode     (mode),
    .upd      (upd),
    .err      (err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [31:0] d, input bit bad_csum);
    send_byte(8'hA5);
    send_byte(a);
    for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
`ifdef KW_CHECKSUM_EN
    send_byte(bad_csum ? 8'h00 : (a ^ d[7:0] ^ d[15:8] ^ d[23:16] ^ d[31:24]));
`endif
  endtask

  // upd must be low in APPLY, high exactly one cycle later, then low again.
  task automatic expect_upd(input string tag);
    @(negedge clk);
    check({tag, "_upd_apply"}, {31'd0, upd}, 32'd0);
    check({tag, "_busy_apply"}, {31'd0, busy}, 32'd1);
    @(negedge clk);
    check({tag, "_upd_pulse"}, {31'd0, upd}, 32'd1);
    check({tag, "_err_pulse"}, {31'd0, err}, 32'd0);
    check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    @(negedge clk);
    check({tag, "_upd_end"}, {31'd0, upd}, 32'd0);
  endtask

  task automatic expect_err(input string tag);
    @(negedge clk);
    check({tag, "_err_pulse"}, {31'd0, err}, 32'd1);
    check({tag, "_upd_low"}, {31'd0, upd}, 32'd0);
    check({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
    @(negedge clk);
    check({tag, "_err_end"}, {31'd0, err}, 32'd0);
  endtask

  initial begin
    int n;
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    exp_aw   = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_fw", fw, 32'd0);
    check("rst_pw", pw, 32'd0);
    check("rst_aw", aw, 32'd0);
    check("rst_mode", mode, 32'd0);
    check("rst_flags", {29'd0, upd, err, busy}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Write+commit fw.
    send_frame(8'h80, 32'h1234_5678, 1'b0);
    expect_upd("fw_commit");
    check("fw_val", fw, 32'h1234_5678);

    // Shadow-only write: nothing visible.
    send_frame(8'h01, 32'hDEAD_BEEF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("shadow_no_upd", {30'd0, upd, err}, 32'd0);
    end
    check("shadow_pw_held", pw, 32'd0);

    // Commit-only.
    send_frame(8'h40, 32'h0, 1'b0);
    expect_upd("commit_only");
    check("commit_pw", pw, 32'hDEAD_BEEF);
    check("commit_fw", fw, 32'h1234_5678);

`ifdef KW_CHECKSUM_EN
    send_frame(8'h82, 32'h0000_0001, 1'b1);
    expect_err("bad_csum");
`else
    send_frame(8'h82, 32'h0000_0001, 1'b0);
    expect_upd("aw_commit");
    exp_aw = 32'h0000_0001;
`endif
    check("aw_val", aw, exp_aw);

    // Timeout: last byte accepted, then 100 idle cycles.
    send_byte(8'hA5);
    send_byte(8'h83);
    n = 0;
    while (n < 300) begin
      @(negedge clk);
      n++;
      if (err) break;
    end
    check("timeout_latency", n, TO + 1);
    check("timeout_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("timeout_err_end", {31'd0, err}, 32'd0);
    check("timeout_mode_held", mode, 32'd0);
    send_frame(8'h83, 32'hCAFE_F00D, 1'b0);
    expect_upd("after_timeout");
    check("mode_val", mode, 32'hCAFE_F00D);

    // Garbage in IDLE is dropped silently; invalid ADDR then errors.
    send_byte(8'h11);
    @(negedge clk);
    check("garbage1", {30'd0, err, busy}, 32'd0);
    send_byte(8'h22);
    @(negedge clk);
    check("garbage2", {30'd0, err, busy}, 32'd0);
    send_frame(8'h05, 32'h0, 1'b0);
    expect_err("bad_addr");
    check("bad_addr_fw", fw, 32'h1234_5678);
    check("bad_addr_pw", pw, 32'hDEAD_BEEF);
    check("bad_addr_aw", aw, exp_aw);
    check("bad_addr_mode", mode, 32'hCAFE_F00D);

    // Reset mid-frame clears everything asynchronously.
    send_byte(8'hA5);
    send_byte(8'h80);
    send_byte(8'h11);
    send_byte(8'h22);
    rst = 1'b1;
    #1;
    check("midrst_fw", fw, 32'd0);
    check("midrst_pw", pw, 32'd0);
    check("midrst_mode", mode, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send_frame(8'h81, 32'h0BAD_F00D, 1'b0);
    expect_upd("after_rst");
    check("after_rst_pw", pw, 32'h0BAD_F00D);
    check("after_rst_fw", fw, 32'd0);
    check("after_rst_aw", aw, 32'd0);
    check("after_rst_mode", mode, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
